// File: rtl/vec_mask_pkg.sv
// Shared types and helpers for the vmadc/vmsbc mask producer.
// Holds sew thermometer codes, FSM state enum and elems_per_beat().
package vec_mask_pkg;

  localparam logic [3:0] SEW_64 = 4'b0001;
  localparam logic [3:0] SEW_32 = 4'b0011;
  localparam logic [3:0] SEW_16 = 4'b0111;
  localparam logic [3:0] SEW_8  = 4'b1111;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } mask_state_e;

  // Thermometer with k ones -> 2^(k-1) elements per beat.
  function automatic int unsigned elems_per_beat(
    input logic [7:0] sew
  );
    int unsigned k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (sew[i]) k++;
    end
    return (k == 0) ? 32'd1 : (32'd1 << (k - 1));
  endfunction

endpackage

// File: rtl/simd_carry_out.sv
// Per-element carry-out / borrow-out of opA +/- opB (+/- cin).
// Ports: sub, carry_en, sew, mask_i, opA, opB in; res_o (LSB-aligned) out.
module simd_carry_out
  import vec_mask_pkg::*;
#(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
  localparam int NE = MAX_WIDTH / MIN_WIDTH
) (
  input  logic                 sub,
  input  logic                 carry_en,
  input  logic [SEW_WIDTH-1:0] sew,
  input  logic [NE-1:0]        mask_i,
  input  logic [MAX_WIDTH-1:0] opA,
  input  logic [MAX_WIDTH-1:0] opB,
  output logic [NE-1:0]        res_o
);

  logic [MAX_WIDTH-1:0] w_opb;
  logic [NE-1:0]        w_lvl [SEW_WIDTH];

  assign w_opb = sub ? ~opB : opB;

  // Level k: element width MAX_WIDTH>>k, 2^k elements.
  for (genvar k = 0; k < SEW_WIDTH; k++) begin : g_lvl
    localparam int W = MAX_WIDTH >> k;
    localparam int N = 1 << k;
    logic [N-1:0] w_bits;
    for (genvar j = 0; j < N; j++) begin : g_el
      logic         w_cin;
      logic [W:0]   w_sum;
      // sub inverts both the carry-in and the carry-out.
      assign w_cin = carry_en ? (mask_i[j] ^ sub) : sub;
      assign w_sum = {1'b0, opA[j*W +: W]}
                   + {1'b0, w_opb[j*W +: W]}
                   + {{W{1'b0}}, w_cin};
      assign w_bits[j] = w_sum[W] ^ sub;
    end
    if (N == NE) begin : g_full
      assign w_lvl[k] = w_bits;
    end else begin : g_pad
      assign w_lvl[k] = {{(NE-N){1'b0}}, w_bits};
    end
  end

  always_comb begin
    res_o = '0;
    for (int k = 0; k < SEW_WIDTH; k++) begin
      if (sew == SEW_WIDTH'((32'd1 << (k + 1)) - 32'd1))
        res_o = w_lvl[k];
    end
  end

endmodule

// File: rtl/simd_mask_carry_gen.sv
// Packs vmadc/vmsbc per-element results into mask words with handshake.
// Ports: valid_i/ready_o beat in, mask_o/mask_cnt_o/mask_valid_o/mask_ready_i out.
// Option: SIMD_MASK_TAIL_ONES_EN drives bits >= mask_cnt_o to 1.
module simd_mask_carry_gen
  import vec_mask_pkg::*;
#(
  parameter int MIN_WIDTH  = 8,
  parameter int MAX_WIDTH  = 64,
  parameter int SEW_WIDTH  = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
  parameter int MASK_WIDTH = 64,
  localparam int NE   = MAX_WIDTH / MIN_WIDTH,
  localparam int CNTW = $clog2(MASK_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  sub,
  input  logic                  carry_en,
  input  logic [SEW_WIDTH-1:0]  sew,
  input  logic [NE-1:0]         mask_i,
  input  logic [MAX_WIDTH-1:0]  opA,
  input  logic [MAX_WIDTH-1:0]  opB,
  input  logic                  last_i,
  output logic [MASK_WIDTH-1:0] mask_o,
  output logic [CNTW-1:0]       mask_cnt_o,
  output logic                  mask_valid_o,
  input  logic                  mask_ready_i
);

  mask_state_e           r_state;
  mask_state_e           w_next;
  logic [CNTW-1:0]       r_ptr;
  logic [CNTW-1:0]       r_cnt;
  logic [MASK_WIDTH-1:0] r_mask;
  logic [SEW_WIDTH-1:0]  r_sew;

  logic                  w_acc;
  logic                  w_start;
  logic                  w_done;
  logic [SEW_WIDTH-1:0]  w_sew;
  logic [NE-1:0]         w_res;
  logic [CNTW-1:0]       w_e;
  logic [CNTW-1:0]       w_ptr;
  logic [CNTW-1:0]       w_nptr;
  logic [MASK_WIDTH-1:0] w_base;
  logic [MASK_WIDTH-1:0] w_nmask;
  logic [MASK_WIDTH-1:0] w_tail;

  assign w_acc   = valid_i && ready_o;
  // A beat taken while in HOLD always opens a fresh word.
  assign w_start = (r_state == HOLD) || (r_ptr == '0);
  assign w_sew   = w_start ? sew : r_sew;
  assign w_ptr   = (r_state == HOLD) ? '0 : r_ptr;
  assign w_base  = (r_state == HOLD) ? '0 : r_mask;
  assign w_e     = CNTW'(elems_per_beat(8'(w_sew)));
  assign w_nptr  = w_ptr + w_e;
  assign w_nmask = w_base | (MASK_WIDTH'(w_res) << w_ptr);
  assign w_done  = (w_nptr == CNTW'(MASK_WIDTH)) || last_i;

  simd_carry_out #(
    .MIN_WIDTH (MIN_WIDTH),
    .MAX_WIDTH (MAX_WIDTH),
    .SEW_WIDTH (SEW_WIDTH)
  ) u_cout (
    .sub      (sub),
    .carry_en (carry_en),
    .sew      (w_sew),
    .mask_i   (mask_i),
    .opA      (opA),
    .opB      (opB),
    .res_o    (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ACC: begin
        if (w_acc && w_done) w_next = HOLD;
      end
      HOLD: begin
        if (mask_ready_i)
          w_next = (w_acc && w_done) ? HOLD : ACC;
      end
      default: w_next = ACC;
    endcase
  end

  always_comb begin
    ready_o      = (r_state == ACC) || mask_ready_i;
    mask_valid_o = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_mask <= '0;
      r_sew  <= '0;
    end else if (w_acc) begin
      r_mask <= w_nmask;
      if (w_start) r_sew <= sew;
      if (w_done) begin
        r_ptr <= '0;
        r_cnt <= w_nptr;
      end else begin
        r_ptr <= w_nptr;
        r_cnt <= '0;
      end
    end else if ((r_state == HOLD) && mask_ready_i) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_mask <= '0;
    end
  end

  always_comb begin
    w_tail = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      w_tail[i] = (CNTW'(i) >= r_cnt);
    end
  end

  assign mask_cnt_o = r_cnt;

`ifdef SIMD_MASK_TAIL_ONES_EN
  assign mask_o = (r_state == HOLD) ? (r_mask | w_tail) : '0;
`else
  // Unwritten bits of r_mask are already zero.
  assign mask_o = (r_state == HOLD) ? (r_mask & ~w_tail) : '0;
`endif

endmodule

// File: doc/simd_mask_carry_gen.md
Name: simd_mask_carry_gen

Overview:
- Vector-lane mask producer for vmadc/vmsbc: computes per-element carry-out (add) or borrow-out (sub) of opA ± opB (± carry/borrow-in).
- Packs one result bit per element into a MASK_WIDTH-bit mask word over successive beats.
- Emits the word to the mask register write path through a valid/ready handshake.
- Sits beside the lane's SIMD adder, on the v0/mask-destination side of the lane.

Parameters:
- MIN_WIDTH, 8, smallest element width in bits.
- MAX_WIDTH, 64, lane datapath width in bits.
- SEW_WIDTH, $clog2(MAX_WIDTH/MIN_WIDTH)+1, width of the sew code.
- MASK_WIDTH, 64, packed mask word width. Must be a multiple of MAX_WIDTH/MIN_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- sub  in  1  1 = borrow-out (vmsbc), 0 = carry-out (vmadc)
- carry_en  in  1  use mask_i as per-element carry/borrow-in
- sew  in  SEW_WIDTH  thermometer element-width code: 0001=64b, 0011=32b, 0111=16b, 1111=8b (for MAX_WIDTH=64)
- mask_i  in  MAX_WIDTH/MIN_WIDTH  packed per-element carry/borrow-in; bit j belongs to element j
- opA  in  MAX_WIDTH  vs2 operand
- opB  in  MAX_WIDTH  vs1/rs1/imm operand
- last_i  in  1  final beat of the vector instruction
- mask_o  out  MASK_WIDTH  packed result mask
- mask_cnt_o  out  $clog2(MASK_WIDTH)+1  number of valid bits in mask_o
- mask_valid_o  out  1  mask word valid
- mask_ready_i  in  1  consumer accepts mask word

Behaviour:
- Elements per beat E = MAX_WIDTH/SEW (8/4/2/1). Element j occupies bits [j*SEW +: SEW].
- Carry-in c_j:
  - add: mask_i[j] if carry_en, else 0.
  - sub: ~mask_i[j] if carry_en, else 1.
- Sum uses opA + (sub ? ~opB : opB) + c_j at SEW+1 bits.
- Result bit: add = bit SEW of the sum; sub = inverted bit SEW (the borrow).
- sew is latched on the first beat of a word. It must be constant until last_i, and later beats use the latched value.
- FSM, 2 states:
  - ACC: collecting. ready_o=1.
  - HOLD: mask_valid_o=1. ready_o = mask_ready_i.
- On an accepted beat in ACC:
  - Write E bits at bit pointer ptr, then ptr += E.
  - If ptr+E == MASK_WIDTH or last_i: go to HOLD next cycle, with mask_cnt_o = ptr+E.
- Latency: accept at cycle t → mask_valid_o at t+1.
- HOLD with mask_ready_i=1:
  - Word retired. Any beat accepted in the same cycle starts a new word at ptr=0: sew is re-latched, and if that beat alone completes a word (fills MASK_WIDTH or has last_i) the FSM stays in HOLD, otherwise it goes to ACC.
  - Without a same-cycle beat: go to ACC, ptr=0, mask_o cleared.
- HOLD with mask_ready_i=0: mask_o, mask_cnt_o and mask_valid_o stay stable.
- Bits at and above mask_cnt_o are 0 (see Optional Feature).
- valid_i=0 leaves all state unchanged.
- Reset values (async reset, any cycle including mid-word): state=ACC, ptr=0, mask_o=0, mask_cnt_o=0, mask_valid_o=0, ready_o=1. A partial word is discarded.

Optional Feature:
- Macro: SIMD_MASK_TAIL_ONES_EN.
- Defined: bits at and above mask_cnt_o in mask_o are driven to 1 (tail-agnostic all-ones).
- Undefined: those bits are 0.
- mask_cnt_o is identical in both builds.

Decomposition:
- Package vec_mask_pkg holds:
  - sew thermometer constants SEW_8/16/32/64
  - state enum mask_state_e {ACC, HOLD}
  - function elems_per_beat(sew)
- One combinational sub-module, simd_carry_out: inputs sub, carry_en, sew, mask_i, opA, opB; output packed E-bit result, LSB-aligned. The top-level module owns the FSM, pointer and packing.

Test Plan:
- SEW8 add, no carry_en, opA=0x00000000_000000FF, opB=0x01, last_i → mask_o=0x01, mask_cnt_o=8, mask_valid_o one cycle after accept.
- SEW8 sub, no carry_en, opA=0, opB=0x0101010101010101, last_i → mask_o=0xFF (all borrows), mask_cnt_o=8.
- SEW32 add, carry_en, mask_i=0x03, opA=0xFFFFFFFF_FFFFFFFF, opB=0 → mask_o=0x3. Repeat with mask_i=0 → 0x0.
- SEW8 streaming, 8 beats of all-carry with no last_i, mask_ready_i=1 → single word 0xFFFF_FFFF_FFFF_FFFF, mask_cnt_o=64, next beat starts a fresh word.
- Backpressure: mask_ready_i=0 while in HOLD for 5 cycles → ready_o=0 and mask_o stable. Raise mask_ready_i with valid_i=1 in the same cycle → old word retired, new beat accepted into ptr=0.
- Assert rst_n mid-word after 3 SEW16 beats → all outputs return to reset values immediately. A following 1-beat last_i word yields mask_cnt_o=4.
